// File: rtl/strobe_latch_bank_if.sv
// Request/status bundle between the bus-cycle FSM (master) and the strobe
// latch bank (slave).
interface strobe_latch_bank_if #(
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS-1:0] SET;
  logic [CHANNELS-1:0] RESET;
  logic                ABORT;
  logic [CHANNELS-1:0] OUT;
  logic [CHANNELS-1:0] PENDING;
  logic                SLOW_RISE;
  logic                SLOW_FALL;

  modport master (
    output SET, RESET, ABORT,
    input  OUT, PENDING, SLOW_RISE, SLOW_FALL
  );

  modport slave (
    input  SET, RESET, ABORT,
    output OUT, PENDING, SLOW_RISE, SLOW_FALL
  );
endinterface

// File: rtl/strobe_latch_bank.sv
// Bank of bus-strobe latches. Set/clear requests from the bus-cycle FSM are
// held pending and applied on a chosen edge of the synchronised slow bus
// clock, with per-channel polarity, a minimum asserted time and an abort.
module strobe_latch_bank #(
  parameter int unsigned         CHANNELS    = 4,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] SET_EDGE    = '0,
  parameter logic [CHANNELS-1:0] CLR_EDGE    = '1,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW  = '1,
  parameter int unsigned         MIN_HOLD    = 3
) (
  input  logic               CLK,
  input  logic               clocked_reset,
  input  logic               SLOW_CLK,
  strobe_latch_bank_if.slave bus
);

  localparam int unsigned      HW        = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam logic [HW-1:0]    HOLD_INIT = HW'(MIN_HOLD);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;
  logic                   fall;
  logic                   slow_rise_q;
  logic                   slow_fall_q;

  logic [CHANNELS-1:0]    asserted_q, asserted_d;
  logic [CHANNELS-1:0]    pend_set_q, pend_set_d;
  logic [CHANNELS-1:0]    pend_clr_q, pend_clr_d;
  logic [HW-1:0]          hold_q [CHANNELS];
  logic [HW-1:0]          hold_d [CHANNELS];
  logic [CHANNELS-1:0]    out_q;
  logic [CHANNELS-1:0]    set_edge;
  logic [CHANNELS-1:0]    clr_edge;

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & hist_q;

  // Channels act on the registered edge pulses, so a request issued in the
  // cycle a SLOW_RISE/SLOW_FALL pulse is visible is served by that pulse.
  assign set_edge = (SET_EDGE & {CHANNELS{slow_fall_q}}) | (~SET_EDGE & {CHANNELS{slow_rise_q}});
  assign clr_edge = (CLR_EDGE & {CHANNELS{slow_fall_q}}) | (~CLR_EDGE & {CHANNELS{slow_rise_q}});

  // Synchronise SLOW_CLK and register one-cycle edge pulses.
  always_ff @(posedge CLK or posedge clocked_reset) begin
    if (clocked_reset) begin
      sync_q      <= '0;
      hist_q      <= 1'b0;
      slow_rise_q <= 1'b0;
      slow_fall_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], SLOW_CLK};
      hist_q      <= sync_q[SYNC_STAGES-1];
      slow_rise_q <= rise;
      slow_fall_q <= fall;
    end
  end

  // Next channel state: requests first, then the qualifying edge, abort last.
  always_comb begin
    asserted_d = asserted_q;
    pend_set_d = pend_set_q;
    pend_clr_d = pend_clr_q;
    hold_d     = hold_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (hold_q[i] != '0) begin
        hold_d[i] = hold_q[i] - HW'(1);
      end
      if (bus.RESET[i]) begin
        pend_set_d[i] = 1'b0;
        if (asserted_q[i]) begin
          pend_clr_d[i] = 1'b1;
        end
      end else if (bus.SET[i]) begin
        pend_clr_d[i] = 1'b0;
        if (!asserted_q[i]) begin
          pend_set_d[i] = 1'b1;
        end
      end
      // Set and clear pendings are mutually exclusive, so at most one fires.
      if (set_edge[i] && pend_set_d[i]) begin
        asserted_d[i] = 1'b1;
        pend_set_d[i] = 1'b0;
        hold_d[i]     = HOLD_INIT;
      end else if (clr_edge[i] && pend_clr_d[i] && (hold_q[i] == '0)) begin
        asserted_d[i] = 1'b0;
        pend_clr_d[i] = 1'b0;
      end
    end
    if (bus.ABORT) begin
      asserted_d = '0;
      pend_set_d = '0;
      pend_clr_d = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hold_d[i] = '0;
      end
    end
  end

  // Channel state and polarity-adjusted strobe outputs.
  always_ff @(posedge CLK or posedge clocked_reset) begin
    if (clocked_reset) begin
      asserted_q <= '0;
      pend_set_q <= '0;
      pend_clr_q <= '0;
      out_q      <= ACTIVE_LOW;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      asserted_q <= asserted_d;
      pend_set_q <= pend_set_d;
      pend_clr_q <= pend_clr_d;
      out_q      <= asserted_d ^ ACTIVE_LOW;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign bus.OUT       = out_q;
  assign bus.PENDING   = pend_set_q | pend_clr_q;
  assign bus.SLOW_RISE = slow_rise_q;
  assign bus.SLOW_FALL = slow_fall_q;

endmodule

// File: tb/tb_strobe_latch_bank.sv
// Bench for strobe_latch_bank: reference model of the strobe rules plus
// directed literal checks and a randomized run.
module tb_strobe_latch_bank;
  localparam int unsigned CH = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned MH = 5;
  localparam logic [3:0]  SE = 4'b0100;
  localparam logic [3:0]  CE = 4'b0111;
  localparam logic [3:0]  AL = 4'b0111;

  logic CLK = 1'b0;
  logic clocked_reset = 1'b1;
  logic SLOW_CLK = 1'b0;

  strobe_latch_bank_if #(.CHANNELS(CH)) bus ();

  strobe_latch_bank #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .SET_EDGE(SE), .CLR_EDGE(CE),
    .ACTIVE_LOW(AL), .MIN_HOLD(MH)
  ) dut (
    .CLK(CLK), .clocked_reset(clocked_reset), .SLOW_CLK(SLOW_CLK), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slow bus clock: toggles every 'half' CLK cycles, changes on negedge.
  int unsigned half = 4;
  int unsigned slow_cnt = 0;
  always @(negedge CLK) begin
    if (slow_cnt + 1 >= half) begin
      slow_cnt = 0;
      SLOW_CLK = ~SLOW_CLK;
    end else begin
      slow_cnt++;
    end
  end

  // Reference model: sampled SLOW_CLK history and per-channel strobe state.
  bit samp [SS+2];
  bit m_rise = 0, m_fall = 0, cr, cf, se, ce;
  bit m_as [CH];
  bit m_ps [CH];
  bit m_pc [CH];
  int m_hold [CH];
  int old_hold;

  task automatic model_reset();
    for (int i = 0; i < SS + 2; i++) samp[i] = 0;
    m_rise = 0;
    m_fall = 0;
    for (int i = 0; i < CH; i++) begin
      m_as[i] = 0; m_ps[i] = 0; m_pc[i] = 0; m_hold[i] = 0;
    end
  endtask

  initial model_reset();

  always @(posedge CLK or posedge clocked_reset) begin
    if (clocked_reset) begin
      model_reset();
    end else begin
      cr = m_rise;
      cf = m_fall;
      // A pulse appears SS+1 cycles after the sampled transition.
      for (int i = SS + 1; i > 0; i--) samp[i] = samp[i-1];
      samp[0] = SLOW_CLK;
      m_rise = samp[SS] && !samp[SS+1];
      m_fall = !samp[SS] && samp[SS+1];
      for (int i = 0; i < CH; i++) begin
        if (bus.ABORT) begin
          m_as[i] = 0; m_ps[i] = 0; m_pc[i] = 0; m_hold[i] = 0;
        end else begin
          if (bus.RESET[i]) begin
            m_ps[i] = 0;
            if (m_as[i]) m_pc[i] = 1;
          end else if (bus.SET[i]) begin
            m_pc[i] = 0;
            if (!m_as[i]) m_ps[i] = 1;
          end
          se = SE[i] ? cf : cr;
          ce = CE[i] ? cf : cr;
          old_hold = m_hold[i];
          m_hold[i] = (old_hold > 0) ? old_hold - 1 : 0;
          if (se && m_ps[i]) begin
            m_as[i] = 1; m_ps[i] = 0; m_hold[i] = MH;
          end else if (ce && m_pc[i] && old_hold == 0) begin
            m_as[i] = 0; m_pc[i] = 0;
          end
        end
      end
    end
  end

  function automatic logic [3:0] exp_out();
    logic [3:0] v;
    for (int i = 0; i < CH; i++) v[i] = m_as[i] ^ AL[i];
    return v;
  endfunction

  function automatic logic [3:0] exp_pend();
    logic [3:0] v;
    for (int i = 0; i < CH; i++) v[i] = m_ps[i] | m_pc[i];
    return v;
  endfunction

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge CLK) begin
    check("OUT", bus.OUT, exp_out());
    check("PENDING", bus.PENDING, exp_pend());
    check("SLOW_RISE", bus.SLOW_RISE, m_rise);
    check("SLOW_FALL", bus.SLOW_FALL, m_fall);
  end

  task automatic wait_pulse(input bit want_fall);
    bit found;
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge CLK);
      found = want_fall ? bus.SLOW_FALL : bus.SLOW_RISE;
    end
    if (!found) check("pulse_timeout", 0, 1);
  endtask

  int lat;

  initial begin
    bus.SET = '0;
    bus.RESET = '0;
    bus.ABORT = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_OUT", bus.OUT, 4'b0111);
    check("rst_PENDING", bus.PENDING, 4'b0000);
    check("rst_RISE", bus.SLOW_RISE, 0);
    clocked_reset = 1'b0;

    // Latency from SLOW_CLK rise to SLOW_RISE pulse, and its width.
    @(posedge SLOW_CLK);
    lat = 0;
    for (int n = 0; n < 10 && !bus.SLOW_RISE; n++) begin
      @(negedge CLK);
      lat++;
    end
    check("rise_latency", lat, 3);
    // SET landing on the pulse cycle asserts on that edge.
    bus.SET = 4'b0001;
    @(negedge CLK);
    bus.SET = '0;
    check("rise_width", bus.SLOW_RISE, 0);
    check("set_on_pulse_OUT", bus.OUT, 4'b0110);
    check("set_on_pulse_PEND", bus.PENDING, 4'b0000);
    // RESET right after assert: first fall falls inside the hold time.
    bus.RESET = 4'b0001;
    @(negedge CLK);
    bus.RESET = '0;
    check("clr_armed", bus.PENDING, 4'b0001);
    wait_pulse(1);
    @(negedge CLK);
    check("hold_block_PEND", bus.PENDING, 4'b0001);
    check("hold_block_OUT", bus.OUT, 4'b0110);
    wait_pulse(1);
    @(negedge CLK);
    check("clr_after_hold_OUT", bus.OUT, 4'b0111);
    check("clr_after_hold_PEND", bus.PENDING, 4'b0000);

    // SET and RESET together on an idle channel: nothing armed.
    bus.SET = 4'b0010;
    bus.RESET = 4'b0010;
    @(negedge CLK);
    bus.SET = '0;
    bus.RESET = '0;
    check("setreset_idle_PEND", bus.PENDING, 4'b0000);
    check("setreset_idle_OUT", bus.OUT, 4'b0111);

    // Three channels asserted on a rise pulse, one pending, then ABORT.
    wait_pulse(0);
    bus.SET = 4'b1011;
    @(negedge CLK);
    bus.SET = 4'b0100;
    check("three_asserted_OUT", bus.OUT, 4'b1100);
    @(negedge CLK);
    bus.SET = '0;
    check("one_pending", bus.PENDING, 4'b0100);
    bus.ABORT = 1'b1;
    @(negedge CLK);
    bus.ABORT = 1'b0;
    check("abort_OUT", bus.OUT, 4'b0111);
    check("abort_PEND", bus.PENDING, 4'b0000);

    // Async reset while a set is pending: request is lost.
    wait_pulse(0);
    @(negedge CLK);
    bus.SET = 4'b0001;
    @(negedge CLK);
    bus.SET = '0;
    check("pend_before_rst", bus.PENDING, 4'b0001);
    #2 clocked_reset = 1'b1;
    #1;
    check("async_rst_OUT", bus.OUT, 4'b0111);
    check("async_rst_PEND", bus.PENDING, 4'b0000);
    @(negedge CLK);
    clocked_reset = 1'b0;
    wait_pulse(0);
    @(negedge CLK);
    check("after_rst_rise_OUT", bus.OUT, 4'b0111);

    // Randomized traffic with varying slow-clock speed.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge CLK);
      if (cyc % 250 == 0) half = $urandom_range(6, 1);
      for (int i = 0; i < CH; i++) begin
        bus.SET[i]   = ($urandom_range(7, 0) == 0);
        bus.RESET[i] = ($urandom_range(9, 0) == 0);
      end
      bus.ABORT = ($urandom_range(99, 0) == 0);
      if ($urandom_range(799, 0) == 0) begin
        #2 clocked_reset = 1'b1;
        #2 clocked_reset = 1'b0;
      end
    end
    @(negedge CLK);
    bus.SET = '0;
    bus.RESET = '0;
    bus.ABORT = 1'b0;
    repeat (4) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
